// File: rtl/mem_write_ctrl_if.sv
// Board-side write bus for mem_write_ctrl: switches, key, readback,
// write ports and status flags.
interface mem_write_ctrl_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic [1:0]        SEL;
    logic [ADDR_W-1:0] ADDR_SW;
    logic [DATA_W-1:0] WDATA;
    logic              WRITE_KEY_N;
    logic [DATA_W-1:0] REG_RDATA;
    logic [DATA_W-1:0] RAM_RDATA;
    logic              REG_WE;
    logic [ADDR_W-1:0] REG_WADDR;
    logic [DATA_W-1:0] REG_WDATA;
    logic              RAM_WE;
    logic [31:0]       RAM_ADDR;
    logic [DATA_W-1:0] RAM_WDATA;
    logic              BUSY;
    logic              DONE;
    logic              ERR;
    logic [1:0]        ERR_CODE;

    modport master (
        input  SEL, ADDR_SW, WDATA, WRITE_KEY_N, REG_RDATA, RAM_RDATA,
        output REG_WE, REG_WADDR, REG_WDATA, RAM_WE, RAM_ADDR, RAM_WDATA,
        output BUSY, DONE, ERR, ERR_CODE
    );

    modport slave (
        output SEL, ADDR_SW, WDATA, WRITE_KEY_N, REG_RDATA, RAM_RDATA,
        input  REG_WE, REG_WADDR, REG_WDATA, RAM_WE, RAM_ADDR, RAM_WDATA,
        input  BUSY, DONE, ERR, ERR_CODE
    );
endinterface

// File: rtl/mem_write_ctrl.sv
// Pushbutton-triggered single-word write to REG file or RAM, followed by
// a readback compare after RD_LAT cycles; reports DONE or ERR.
module mem_write_ctrl #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int RD_LAT = 2
) (
    input  logic            CLOCK,
    input  logic            RESET_N,
    mem_write_ctrl_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_WRITE, S_WAIT, S_CHECK, S_DONE, S_ERR
    } state_t;

    localparam logic [3:0] LAT = 4'(RD_LAT);

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              sel_ram_q, sel_ram_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              reg_we_q, reg_we_d;
    logic              ram_we_q, ram_we_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [1:0]        code_q, code_d;
    logic              key_s1_q, key_s2_q, key_prev_q;
    logic              press;
    logic [DATA_W-1:0] rdata;

    assign press = !key_s2_q && key_prev_q;
    assign rdata = sel_ram_q ? bus.RAM_RDATA : bus.REG_RDATA;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sel_ram_d = sel_ram_q;
        addr_d    = addr_q;
        data_d    = data_q;
        reg_we_d  = 1'b0;
        ram_we_d  = 1'b0;
        busy_d    = busy_q;
        done_d    = done_q;
        err_d     = err_q;
        code_d    = code_q;
        unique case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (press) begin
                    sel_ram_d = bus.SEL[0];
                    addr_d    = bus.ADDR_SW;
                    data_d    = bus.WDATA;
                    done_d    = 1'b0;
                    err_d     = 1'b0;
                    code_d    = 2'd0;
                    if (bus.SEL[1]) begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                        code_d  = 2'd1;
                    end else if (!bus.SEL[0] && bus.ADDR_SW == '0) begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                        code_d  = 2'd2;
                    end else begin
                        state_d  = S_WRITE;
                        busy_d   = 1'b1;
                        reg_we_d = !bus.SEL[0];
                        ram_we_d = bus.SEL[0];
                    end
                end
            end
            S_WRITE: begin
                state_d = S_WAIT;
                cnt_d   = LAT;
            end
            S_WAIT: begin
                if (cnt_q <= 4'd1) state_d = S_CHECK;
                else cnt_d = cnt_q - 4'd1;
            end
            S_CHECK: begin
                busy_d = 1'b0;
                if (rdata == data_q) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d = S_ERR;
                    err_d   = 1'b1;
                    code_d  = 2'd3;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            sel_ram_q  <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            reg_we_q   <= 1'b0;
            ram_we_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            code_q     <= 2'd0;
            key_s1_q   <= 1'b1;
            key_s2_q   <= 1'b1;
            key_prev_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sel_ram_q  <= sel_ram_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            reg_we_q   <= reg_we_d;
            ram_we_q   <= ram_we_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            code_q     <= code_d;
            key_s1_q   <= bus.WRITE_KEY_N;
            key_s2_q   <= key_s1_q;
            key_prev_q <= key_s2_q;
        end
    end

    assign bus.REG_WE    = reg_we_q;
    assign bus.RAM_WE    = ram_we_q;
    assign bus.REG_WADDR = addr_q;
    assign bus.RAM_ADDR  = {{(30-ADDR_W){1'b0}}, addr_q, 2'b00};
    assign bus.REG_WDATA = data_q;
    assign bus.RAM_WDATA = data_q;
    assign bus.BUSY      = busy_q;
    assign bus.DONE      = done_q;
    assign bus.ERR       = err_q;
    assign bus.ERR_CODE  = code_q;
endmodule

// File: tb/tb_mem_write_ctrl.sv
// Scoreboard bench for mem_write_ctrl: main DUT at RD_LAT=2 with a memory
// model, plus RD_LAT=1 and RD_LAT=4 copies for DONE timing.
module tb_mem_write_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  sel = 2'd0;
    logic [4:0]  addr_sw = 5'd0;
    logic [31:0] wdata = 32'd0;
    logic        key_n = 1'b1;
    logic        corrupt = 1'b0;
    int          cyc = 0;
    int          vectors = 0;
    int          miscompares = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_write_ctrl_if #(.DATA_W(32), .ADDR_W(5)) bus ();
    mem_write_ctrl_if #(.DATA_W(32), .ADDR_W(5)) bus1 ();
    mem_write_ctrl_if #(.DATA_W(32), .ADDR_W(5)) bus4 ();

    mem_write_ctrl #(.DATA_W(32), .ADDR_W(5), .RD_LAT(2)) dut (
        .CLOCK(clk), .RESET_N(rst_n), .bus(bus.master));
    mem_write_ctrl #(.DATA_W(32), .ADDR_W(5), .RD_LAT(1)) dut1 (
        .CLOCK(clk), .RESET_N(rst_n), .bus(bus1.master));
    mem_write_ctrl #(.DATA_W(32), .ADDR_W(5), .RD_LAT(4)) dut4 (
        .CLOCK(clk), .RESET_N(rst_n), .bus(bus4.master));

    assign bus.SEL = sel;
    assign bus.ADDR_SW = addr_sw;
    assign bus.WDATA = wdata;
    assign bus.WRITE_KEY_N = key_n;
    assign bus1.SEL = sel;
    assign bus1.ADDR_SW = addr_sw;
    assign bus1.WDATA = wdata;
    assign bus1.WRITE_KEY_N = key_n;
    assign bus4.SEL = sel;
    assign bus4.ADDR_SW = addr_sw;
    assign bus4.WDATA = wdata;
    assign bus4.WRITE_KEY_N = key_n;

    // Memory model for the main DUT; copies read back their own write data
    logic [31:0] regs [32];
    logic [31:0] ram [32];
    initial begin
        for (int i = 0; i < 32; i++) begin
            regs[i] = 32'd0;
            ram[i] = 32'd0;
        end
    end
    always @(posedge clk) begin
        if (bus.REG_WE) regs[bus.REG_WADDR] <= bus.REG_WDATA;
        if (bus.RAM_WE) ram[bus.RAM_ADDR[6:2]] <= bus.RAM_WDATA;
    end
    assign bus.REG_RDATA = regs[bus.REG_WADDR] ^ {31'd0, corrupt};
    assign bus.RAM_RDATA = ram[bus.RAM_ADDR[6:2]];
    assign bus1.REG_RDATA = bus1.REG_WDATA;
    assign bus1.RAM_RDATA = bus1.RAM_WDATA;
    assign bus4.REG_RDATA = bus4.REG_WDATA;
    assign bus4.RAM_RDATA = bus4.RAM_WDATA;

    typedef struct {
        logic        done;
        logic        err;
        logic [1:0]  code;
        int          regwe;
        int          ramwe;
        logic [31:0] we_addr;
        int          cyc;
    } exp_t;
    exp_t q[$];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops one expectation per new DONE/ERR status
    int          reg_cnt = 0;
    int          ram_cnt = 0;
    logic [31:0] we_addr = 32'd0;
    logic [4:0]  prev_stat = 5'd0;
    always @(negedge clk) begin
        logic [4:0] stat;
        exp_t e;
        if (!rst_n) begin
            reg_cnt = 0;
            ram_cnt = 0;
            prev_stat = 5'd0;
        end else begin
            chk("we_exclusive", {63'd0, bus.REG_WE & bus.RAM_WE}, 64'd0);
            if (bus.REG_WE) begin
                reg_cnt++;
                we_addr = {27'd0, bus.REG_WADDR};
            end
            if (bus.RAM_WE) begin
                ram_cnt++;
                we_addr = bus.RAM_ADDR;
            end
            stat = {bus.DONE, bus.ERR, bus.BUSY, bus.ERR_CODE};
            if (stat != prev_stat && (bus.DONE || bus.ERR)) begin
                if (q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_event: status %0h at cycle %0d expected none",
                             stat, cyc);
                end else begin
                    e = q.pop_front();
                    chk("done", {63'd0, bus.DONE}, {63'd0, e.done});
                    chk("err", {63'd0, bus.ERR}, {63'd0, e.err});
                    chk("err_code", {62'd0, bus.ERR_CODE}, {62'd0, e.code});
                    chk("busy_end", {63'd0, bus.BUSY}, 64'd0);
                    chk("reg_we_count", 64'(reg_cnt), 64'(e.regwe));
                    chk("ram_we_count", 64'(ram_cnt), 64'(e.ramwe));
                    chk("status_cycle", 64'(cyc), 64'(e.cyc));
                    if (e.regwe + e.ramwe > 0)
                        chk("we_addr", {32'd0, we_addr}, {32'd0, e.we_addr});
                end
                reg_cnt = 0;
                ram_cnt = 0;
            end
            prev_stat = stat;
        end
    end

    int   rise1 = -1;
    int   rise4 = -1;
    logic d1_prev = 1'b0;
    logic d4_prev = 1'b0;
    always @(negedge clk) begin
        if (bus1.DONE && !d1_prev) rise1 = cyc;
        if (bus4.DONE && !d4_prev) rise4 = cyc;
        d1_prev = bus1.DONE;
        d4_prev = bus4.DONE;
    end

    // Called at a negedge; key goes low, edge 1 is the next posedge
    task automatic press(input logic [1:0] s, input logic [4:0] a,
                         input logic [31:0] d, input bit bad, input bit push,
                         input int hold, output int n);
        exp_t e;
        logic [1:0] code;
        bit wes;
        sel = s;
        addr_sw = a;
        wdata = d;
        corrupt = bad;
        key_n = 1'b0;
        n = cyc;
        code = s[1] ? 2'd1 : (s == 2'd0 && a == 5'd0) ? 2'd2 : bad ? 2'd3 : 2'd0;
        wes = (code == 2'd0 || code == 2'd3);
        e.done = (code == 2'd0);
        e.err = (code != 2'd0);
        e.code = code;
        e.regwe = (wes && s == 2'd0) ? 1 : 0;
        e.ramwe = (wes && s == 2'd1) ? 1 : 0;
        e.we_addr = (s == 2'd0) ? {27'd0, a} : {25'd0, a, 2'b00};
        e.cyc = wes ? n + 7 : n + 3;
        if (push) q.push_back(e);
        repeat (hold) @(negedge clk);
        key_n = 1'b1;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200 && q.size() != 0; i++) @(negedge clk);
        if (q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL timeout: %0d events pending expected 0", q.size());
            q.delete();
        end
        repeat (6) @(negedge clk);
    endtask

    function automatic logic [63:0] all_out();
        return {32'd0, bus.REG_WE, bus.RAM_WE, bus.BUSY, bus.DONE, bus.ERR,
                bus.ERR_CODE, bus.REG_WADDR} | 64'(bus.RAM_ADDR)
               | 64'(bus.REG_WDATA) | 64'(bus.RAM_WDATA);
    endfunction

    initial begin
        int n;
        #23;
        chk("reset_outputs", all_out(), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Reset during WAIT aborts: no expectation pushed
        press(2'd1, 5'd3, 32'hDEADBEEF, 1'b0, 1'b0, 1, n);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("reset_midop_outputs", all_out(), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("reset_midop_quiet", {62'd0, bus.BUSY, bus.DONE}, 64'd0);

        press(2'd1, 5'd5, 32'h12345678, 1'b0, 1'b1, 1, n);
        wait_idle();
        chk("ram_addr", {32'd0, bus.RAM_ADDR}, 64'h14);

        press(2'd2, 5'd4, 32'h1, 1'b0, 1'b1, 1, n);
        wait_idle();
        press(2'd0, 5'd0, 32'h2, 1'b0, 1'b1, 1, n);
        wait_idle();
        press(2'd3, 5'd6, 32'h3, 1'b0, 1'b1, 1, n);
        wait_idle();

        press(2'd0, 5'd7, 32'hA5A5A5A5, 1'b1, 1'b1, 1, n);
        wait_idle();
        corrupt = 1'b0;

        // From ERR: capture edge clears status; copies give RD_LAT 1/4 timing
        press(2'd0, 5'd9, 32'h0BADF00D, 1'b0, 1'b1, 1, n);
        @(negedge clk);
        @(negedge clk);
        chk("clear_on_capture", {61'd0, bus.ERR, bus.ERR_CODE, bus.BUSY},
            {61'd0, 1'b0, 2'd0, 1'b1});
        wait_idle();
        chk("done_rise_lat1", 64'(rise1), 64'(n + 6));
        chk("done_rise_lat4", 64'(rise4), 64'(n + 9));

        // Second press lands in WAIT and must be dropped
        press(2'd0, 5'd10, 32'hCAFE0001, 1'b0, 1'b1, 1, n);
        @(negedge clk);
        key_n = 1'b0;
        @(negedge clk);
        key_n = 1'b1;
        wait_idle();
        repeat (10) @(negedge clk);

        press(2'd1, 5'd11, 32'h00C0FFEE, 1'b0, 1'b1, 50, n);
        wait_idle();

        press(2'd0, 5'd12, 32'h13572468, 1'b0, 1'b1, 1, n);
        @(negedge clk);
        @(negedge clk);
        wdata = 32'hFFFF0000;
        @(negedge clk);
        chk("wdata_held", {32'd0, bus.REG_WDATA}, 64'h13572468);
        wait_idle();
        chk("reg_model", {32'd0, regs[12]}, 64'h13572468);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/mem_write_ctrl.md
Name: mem_write_ctrl

Overview:
- Write-side companion to the memory/register display selector.
- Takes a switch-selected target (REG file or RAM), a switch address and a data word, and commits the word on a pushbutton press.
- Reads the location back after a programmable latency and reports DONE or ERR.
- Sits between the board switches/keys and the RAM/register-file write ports.

Parameters:
DATA_W, 32, data word width
ADDR_W, 5, switch address width
RD_LAT, 2, cycles from write-enable deassertion to valid readback data (1..15)

Ports:
CLOCK  in  1  system clock, all state on rising edge
RESET_N  in  1  asynchronous active-low reset
SEL  in  2  target: 0=REG, 1=RAM, 2=ROM (read-only), 3=invalid
ADDR_SW  in  ADDR_W  word/register address from switches
WDATA  in  DATA_W  data to write
WRITE_KEY_N  in  1  raw pushbutton, active-low, asynchronous to CLOCK
REG_RDATA  in  DATA_W  register-file readback at REG_WADDR
RAM_RDATA  in  DATA_W  RAM readback at RAM_ADDR
REG_WE  out  1  register-file write enable, one-cycle pulse
REG_WADDR  out  ADDR_W  register write/readback address
REG_WDATA  out  DATA_W  register write data
RAM_WE  out  1  RAM write enable, one-cycle pulse
RAM_ADDR  out  32  RAM byte address = 4*captured address, zero-extended
RAM_WDATA  out  DATA_W  RAM write data
BUSY  out  1  operation in progress
DONE  out  1  last operation verified OK
ERR  out  1  last operation failed
ERR_CODE  out  2  0=none, 1=ROM/invalid target, 2=write to REG 0, 3=readback mismatch

Behaviour:
- Reset (RESET_N low, asynchronous): state IDLE. All outputs 0, including both WE, all address/data outputs, BUSY, DONE, ERR and ERR_CODE. Synchronizer flops set to 1 (key released).
- Reset asserted mid-operation aborts at once: no further WE pulse, no status update.
- Key input path:
  - 2-flop synchronizer on WRITE_KEY_N, then a registered previous value.
  - Press = synchronized value 0 while previous value 1; one cycle per press.
  - A key held low produces one press only.
  - Press timing: KEY first sampled low at edge 1 gives a press detected at edge 3.
- States: IDLE, WRITE, WAIT, CHECK, DONE, ERR.
- IDLE / DONE / ERR on press:
  - Capture SEL, ADDR_SW and WDATA into internal registers. Later switch changes do not affect the operation.
  - Clear DONE, ERR and ERR_CODE.
  - SEL=2 or 3: go to ERR with code 1, no WE.
  - SEL=0 and ADDR_SW=0: go to ERR with code 2, no WE.
  - Otherwise go to WRITE and set BUSY=1.
- Address/data outputs load on capture and hold until the next capture.
  - REG_WADDR = captured address.
  - RAM_ADDR = {zeros, address, 2'b00}.
  - Both WDATA outputs = captured data.
- WRITE: exactly one cycle.
  - Target's WE=1 (REG_WE if SEL=0, RAM_WE if SEL=1); the other WE stays 0.
  - Registered outputs: WE is high between edges 3 and 4 of the press timing above.
  - Next state WAIT.
- WAIT: counter loaded with RD_LAT, decrements each cycle; at 1, go to CHECK.
- CHECK: one cycle. Compare the selected readback with the captured data.
  - Equal: DONE=1, state DONE.
  - Not equal: ERR=1, ERR_CODE=3, state ERR.
  - BUSY clears on the same edge.
  - With RD_LAT=2, DONE rises at edge 7 (press detected at edge 3).
- DONE / ERR: flags hold until the next press or reset.
- Presses while BUSY (WRITE, WAIT, CHECK) are ignored and not queued.
- At most one WE is high in any cycle. No WE is ever high outside WRITE.

Test Plan:
- Reset mid-op: release reset, press with SEL=1, ADDR_SW=3, WDATA=0xDEADBEEF; assert RESET_N=0 during WAIT. Required: all outputs 0 immediately and no RAM_WE afterwards.
- RAM write OK: SEL=1, ADDR_SW=5, WDATA=0x12345678, press; model returns written data. Required: RAM_ADDR=0x14, RAM_WE high exactly one cycle, REG_WE never high, DONE=1, BUSY=0, ERR_CODE=0.
- Illegal targets:
  - SEL=2 press gives ERR=1, ERR_CODE=1, no WE.
  - SEL=0, ADDR_SW=0 press gives ERR_CODE=2, no WE.
  - SEL=3 gives code 1.
- Readback mismatch: SEL=0, ADDR_SW=7, WDATA=0xA5A5A5A5; model returns 0xA5A5A5A4. Required: REG_WE pulse at REG_WADDR=7, then ERR=1, ERR_CODE=3.
- Busy and hold:
  - Second press during WAIT is ignored: one WE pulse total.
  - Key held low for 50 cycles gives one operation.
  - Changing WDATA after capture does not alter REG_WDATA.
- Status clearing: after ERR, a new valid press clears ERR and ERR_CODE on the capture edge and ends in DONE. Repeat with RD_LAT=1 and RD_LAT=4 to check the DONE timing.
